io_bus_responder: RTL and testbench

- Target side of the core's data-memory/IO bus. Decodes the address the pipeline drives in its MEM stage and serves loads and stores.
- Contains the data RAM (combinational read, synchronous write) with byte/half/word lane handling and load extension.
- Contains the memory-mapped peripherals: LED register, switch input, 32-bit cycle timer, and an 8-digit hex display register with a scan sequencer.
- Sits at top level between the core's mem_* port group and board pins.

---
 rtl/io_bus_responder.sv | 127 ++++++++++++
 tb/tb_io_bus_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/io_bus_responder.sv
// Data-memory/IO bus target: data RAM with byte/half/word lanes plus LED, switch,
// cycle timer and scanned hex display registers. Reads are zero-latency.
module io_bus_responder #(
  parameter int unsigned DRAM_AW    = 14,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter logic [31:0] SEG_ADDR   = 32'hFFFF_F000,
  parameter logic [31:0] TIMER_ADDR = 32'hFFFF_F020,
  parameter logic [31:0] LED_ADDR   = 32'hFFFF_F060,
  parameter logic [31:0] SW_ADDR    = 32'hFFFF_F070
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addr,
  input  logic [3:0]  bus_ctrl,
  input  logic [31:0] bus_wd,
  input  logic        bus_we,
  output logic [31:0] bus_rd,
  input  logic [23:0] sw_i,
  output logic [23:0] led_o,
  output logic [7:0]  seg_an_o,
  output logic [3:0]  seg_nibble_o
);
  localparam int unsigned PW   = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  logic       uns;
  logic [1:0] typ;
  logic       wr;
  logic       dram_hit, seg_hit, timer_hit, led_hit, sw_hit;
  logic [DRAM_AW-1:0] widx;

  assign uns       = bus_ctrl[3];
  assign typ       = bus_ctrl[2:1];
  assign wr        = bus_we & bus_ctrl[0];
  assign widx      = bus_addr[DRAM_AW+1:2];
  assign dram_hit  = (bus_addr[31:DRAM_AW+2] == '0);
  assign seg_hit   = (bus_addr[31:2] == SEG_ADDR[31:2]);
  assign timer_hit = (bus_addr[31:2] == TIMER_ADDR[31:2]);
  assign led_hit   = (bus_addr[31:2] == LED_ADDR[31:2]);
  assign sw_hit    = (bus_addr[31:2] == SW_ADDR[31:2]);

  // ---------------- data RAM ----------------
  logic [31:0] mem [0:(1<<DRAM_AW)-1];
  logic [31:0] rword;
  logic [3:0]  be;
  logic [31:0] wdata;

  assign rword = mem[widx];

  // Store data is replicated across lanes so each byte enable picks its own copy.
  always_comb begin
    be    = 4'hF;
    wdata = bus_wd;
    case (typ)
      2'b01: begin
        be    = bus_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus_wd[15:0]}};
      end
      2'b10: begin
        be    = 4'b0001 << bus_addr[1:0];
        wdata = {4{bus_wd[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr && dram_hit) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  logic [31:0] dram_rd;
  logic [15:0] rhalf;
  logic [7:0]  rbyte;

  always_comb begin
    rhalf   = bus_addr[1] ? rword[31:16] : rword[15:0];
    rbyte   = rword[8*bus_addr[1:0] +: 8];
    dram_rd = rword;
    case (typ)
      2'b01:   dram_rd = {{16{~uns & rhalf[15]}}, rhalf};
      2'b10:   dram_rd = {{24{~uns & rbyte[7]}}, rbyte};
      default: ;
    endcase
  end

  // ---------------- peripherals ----------------
  logic [31:0]   seg;
  logic [31:0]   timer;
  logic [PW-1:0] presc;
  logic [2:0]    idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_o        <= '0;
      seg          <= '0;
      timer        <= '0;
      presc        <= '0;
      idx          <= '0;
      seg_an_o     <= 8'hFE;
      seg_nibble_o <= '0;
    end else begin
      if (wr && led_hit) led_o <= bus_wd[23:0];
      if (wr && seg_hit) seg   <= bus_wd;
      timer <= (wr && timer_hit) ? bus_wd : timer + 32'd1;
      if (presc == PMAX) begin
        presc <= '0;
        idx   <= idx + 3'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      seg_an_o     <= ~(8'b1 << idx);
      seg_nibble_o <= seg[4*idx +: 4];
    end
  end

  always_comb begin
    bus_rd = '0;
    if (dram_hit)       bus_rd = dram_rd;
    else if (led_hit)   bus_rd = {8'b0, led_o};
    else if (sw_hit)    bus_rd = {8'b0, sw_i};
    else if (timer_hit) bus_rd = timer;
    else if (seg_hit)   bus_rd = seg;
  end
endmodule

// File: tb/tb_io_bus_responder.sv
// Directed bench for io_bus_responder: RAM lanes/extension, peripherals, timer wrap,
// display scan and asynchronous reset.
module tb_io_bus_responder;
  localparam logic [31:0] SEG_ADDR   = 32'hFFFF_F000;
  localparam logic [31:0] TIMER_ADDR = 32'hFFFF_F020;
  localparam logic [31:0] LED_ADDR   = 32'hFFFF_F060;
  localparam logic [31:0] SW_ADDR    = 32'hFFFF_F070;
  localparam logic [1:0] T_W = 2'b00, T_H = 2'b01, T_B = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bus_addr;
  logic [3:0]  bus_ctrl;
  logic [31:0] bus_wd;
  logic        bus_we;
  logic [31:0] bus_rd;
  logic [23:0] sw_i;
  logic [23:0] led_o;
  logic [7:0]  seg_an_o;
  logic [3:0]  seg_nibble_o;

  int checks = 0;
  int errors = 0;

  io_bus_responder #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_ctrl(bus_ctrl),
    .bus_wd(bus_wd), .bus_we(bus_we), .bus_rd(bus_rd), .sw_i(sw_i),
    .led_o(led_o), .seg_an_o(seg_an_o), .seg_nibble_o(seg_nibble_o)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in the low clock phase; returns one negedge later with the store committed.
  task automatic wr(input logic [31:0] a, input logic [1:0] t, input logic [31:0] d);
    bus_addr = a;
    bus_ctrl = {1'b0, t, 1'b1};
    bus_we   = 1'b1;
    bus_wd   = d;
    @(negedge clk);
    bus_we   = 1'b0;
    bus_ctrl = 4'b0000;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [1:0] t,
                        input logic u, input logic [31:0] exp);
    bus_addr = a;
    bus_ctrl = {u, t, 1'b0};
    bus_we   = 1'b0;
    #1;
    check(tag, bus_rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prev, one, exp_an;
    logic       found;

    rst_n = 1'b1; bus_addr = '0; bus_ctrl = '0; bus_wd = '0; bus_we = 1'b0; sw_i = '0;
    #5 rst_n = 1'b0;
    #25;
    check("rst_led", {8'b0, led_o}, 32'h0);
    check("rst_an", {24'b0, seg_an_o}, 32'hFE);
    check("rst_nib", {28'b0, seg_nibble_o}, 32'h0);
    chk_rd("rst_timer", TIMER_ADDR, T_W, 1'b0, 32'h0);
    chk_rd("rst_seg", SEG_ADDR, T_W, 1'b0, 32'h0);
    #100 rst_n = 1'b1;

    // timer: 10 edges after release, then load and wrap
    repeat (10) @(negedge clk);
    chk_rd("timer_10", TIMER_ADDR, T_W, 1'b0, 32'd10);
    wr(TIMER_ADDR, T_W, 32'hFFFF_FFFE);
    chk_rd("timer_load", TIMER_ADDR, T_W, 1'b0, 32'hFFFF_FFFE);
    @(negedge clk);
    chk_rd("timer_max", TIMER_ADDR, T_W, 1'b0, 32'hFFFF_FFFF);
    @(negedge clk);
    chk_rd("timer_wrap", TIMER_ADDR, T_W, 1'b0, 32'h0);

    // DRAM lanes and extension
    wr(32'h0000_0000, T_W, 32'h1111_1111);
    wr(32'h0000_0010, T_W, 32'h8123_4567);
    chk_rd("ld_w10", 32'h10, T_W, 1'b0, 32'h8123_4567);
    chk_rd("ld_b13_s", 32'h13, T_B, 1'b0, 32'hFFFF_FF81);
    chk_rd("ld_b13_u", 32'h13, T_B, 1'b1, 32'h0000_0081);
    chk_rd("ld_b11_s", 32'h11, T_B, 1'b0, 32'h0000_0045);
    chk_rd("ld_b12_u", 32'h12, T_B, 1'b1, 32'h0000_0023);
    chk_rd("ld_h10_s", 32'h10, T_H, 1'b0, 32'h0000_4567);
    wr(32'h0000_0012, T_H, 32'h5555_BEEF);
    chk_rd("st_h_w", 32'h10, T_W, 1'b0, 32'hBEEF_4567);
    chk_rd("ld_h12_s", 32'h12, T_H, 1'b0, 32'hFFFF_BEEF);
    chk_rd("ld_h13_u", 32'h13, T_H, 1'b1, 32'h0000_BEEF);
    wr(32'h0000_0010, T_B, 32'h1234_56AA);
    chk_rd("st_b_w", 32'h10, T_W, 1'b0, 32'hBEEF_45AA);
    wr(32'h0000_FFFC, T_W, 32'hCAFE_F00D);
    chk_rd("ld_top", 32'h0000_FFFC, T_W, 1'b0, 32'hCAFE_F00D);
    wr(32'h0001_0000, T_W, 32'hDEAD_BEEF);
    chk_rd("unmap_rd_10000", 32'h0001_0000, T_W, 1'b0, 32'h0);
    chk_rd("no_alias_0", 32'h0, T_W, 1'b0, 32'h1111_1111);

    // LED, switches, unmapped space
    wr(LED_ADDR, T_W, 32'h00FF_00F0);
    check("led_o", {8'b0, led_o}, 32'h00FF_00F0);
    chk_rd("led_rd", LED_ADDR, T_B, 1'b0, 32'h00FF_00F0);
    sw_i = 24'h123456;
    chk_rd("sw_rd", SW_ADDR, T_W, 1'b0, 32'h0012_3456);
    wr(SW_ADDR, T_W, 32'hFFFF_FFFF);
    chk_rd("sw_rd_after_wr", SW_ADDR, T_W, 1'b0, 32'h0012_3456);
    check("led_after_sw_wr", {8'b0, led_o}, 32'h00FF_00F0);
    wr(32'h8000_0000, T_W, 32'hAA55_AA55);
    chk_rd("unmap_rd", 32'h8000_0000, T_W, 1'b0, 32'h0);
    chk_rd("unmap_dram_kept", 32'h10, T_W, 1'b0, 32'hBEEF_45AA);
    check("unmap_led_kept", {8'b0, led_o}, 32'h00FF_00F0);

    // display scan
    wr(SEG_ADDR, T_W, 32'h8765_4321);
    chk_rd("seg_rd", SEG_ADDR, T_W, 1'b0, 32'h8765_4321);
    found = 1'b0;
    prev  = seg_an_o;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (seg_an_o == 8'hFE && prev == 8'h7F) found = 1'b1;
      prev = seg_an_o;
    end
    check("scan_align", {31'b0, found}, 32'h1);
    one = 8'h01;
    for (int k = 0; k < 9; k++) begin
      exp_an = ~(one << (k % 8));
      check($sformatf("scan_an_%0d", k), {24'b0, seg_an_o}, {24'b0, exp_an});
      check($sformatf("scan_nib_%0d", k), {28'b0, seg_nibble_o}, 32'((k % 8) + 1));
      repeat (3) @(negedge clk);
      check($sformatf("scan_dwell_%0d", k), {24'b0, seg_an_o}, {24'b0, exp_an});
      @(negedge clk);
    end

    // asynchronous reset mid-scan
    @(negedge clk);
    check("pre_rst_an", {24'b0, seg_an_o}, 32'hFD);
    #10 rst_n = 1'b0;
    #1;
    check("mid_rst_an", {24'b0, seg_an_o}, 32'hFE);
    check("mid_rst_nib", {28'b0, seg_nibble_o}, 32'h0);
    check("mid_rst_led", {8'b0, led_o}, 32'h0);
    chk_rd("mid_rst_seg", SEG_ADDR, T_W, 1'b0, 32'h0);
    chk_rd("mid_rst_timer", TIMER_ADDR, T_W, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
